// File: rtl/spmm_out_collector.sv
// spmm_out_collector: double-buffered N x N result collector for the SpMM PE array.
// Result rows are written (or accumulated, output-stationary) into one of two banks;
// a completed bank is drained four rows per beat over N/4 beats.
module spmm_out_collector #(
  parameter int N   = 16,
  parameter int W   = 8,
  parameter int LGN = $clog2(N)
) (
  input  logic               clock,
  input  logic               reset,
  output logic               res_ready,
  input  logic               res_valid,
  input  logic               res_os,
  input  logic [LGN-1:0]     res_row,
  input  logic [N*W-1:0]     res_data,
  output logic               out_ready,
  input  logic               out_start,
  output logic               out_valid,
  output logic [4*N*W-1:0]   out_data
);

  localparam logic [1:0] S_EMPTY    = 2'd0;
  localparam logic [1:0] S_FILLING  = 2'd1;
  localparam logic [1:0] S_FULL     = 2'd2;
  localparam logic [1:0] S_DRAINING = 2'd3;

  localparam int NB = N / 4;
  localparam int DW = (LGN > 2) ? LGN - 2 : 1;
  localparam logic [LGN-1:0] ROW_LAST  = LGN'(N - 1);
  localparam logic [DW-1:0]  DCNT_LAST = DW'(NB - 1);

  logic [1:0]      st [2];
  logic            fp, dp, lp;
  logic            tgt, acc;
  logic [LGN-1:0]  rcnt;
  logic [DW-1:0]   dcnt;
  logic [N*W-1:0]  mem [2][N];

  logic            xfer;
  logic            start_acc;
  logic            cur_tgt;
  logic            cur_acc;
  logic            tile_done;
  logic            drain_go;
  logic            drain_active;
  logic            beat_last;
  logic [N*W-1:0]  new_row;
  logic [4*N*W-1:0] beat;

  // Handshake, tile target selection and drain control decode.
  always_comb begin
    start_acc    = res_os & (st[lp] == S_FULL);
    res_ready    = (rcnt != '0) | (st[fp] == S_EMPTY) | start_acc;
    xfer         = res_valid & res_ready;
    cur_tgt      = (rcnt == '0) ? (start_acc ? lp : fp) : tgt;
    cur_acc      = (rcnt == '0) ? start_acc : acc;
    tile_done    = xfer & (rcnt == ROW_LAST);
    out_ready    = (st[dp] == S_FULL);
    drain_go     = out_start & out_ready;
    drain_active = (st[dp] == S_DRAINING);
    beat_last    = drain_active & (dcnt == DCNT_LAST);
  end

  // Row to store: raw data in WRITE mode, element-wise wrapping sum in ACC mode.
  always_comb begin
    new_row = res_data;
    if (cur_acc) begin
      for (int unsigned j = 0; j < N; j++) begin
        new_row[j*W +: W] = mem[cur_tgt][res_row][j*W +: W] + res_data[j*W +: W];
      end
    end
  end

  // Four consecutive rows of the drain bank for the current beat.
  always_comb begin
    beat = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      beat[i*N*W +: N*W] = mem[dp][LGN'({dcnt, 2'(i)})];
    end
  end

  // Bank storage; deliberately not reset, WRITE tiles overwrite stale contents.
  always_ff @(posedge clock) begin
    if (!reset && xfer) begin
      mem[cur_tgt][res_row] <= new_row;
    end
  end

  // Bank state, pointers, counters and drain output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      st[0]     <= S_EMPTY;
      st[1]     <= S_EMPTY;
      fp        <= 1'b0;
      dp        <= 1'b0;
      lp        <= 1'b0;
      tgt       <= 1'b0;
      acc       <= 1'b0;
      rcnt      <= '0;
      dcnt      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      // Fill side; completion overrides the FILLING mark when both apply.
      if (xfer) begin
        if (rcnt == '0) begin
          tgt          <= cur_tgt;
          acc          <= cur_acc;
          st[cur_tgt]  <= S_FILLING;
        end
        if (tile_done) begin
          st[cur_tgt] <= S_FULL;
          lp          <= cur_tgt;
          fp          <= ~cur_tgt;
          rcnt        <= '0;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end

      // Drain side; fill and drain never address the same bank in legal use.
      out_valid <= 1'b0;
      if (drain_go) begin
        st[dp] <= S_DRAINING;
        dcnt   <= '0;
      end else if (drain_active) begin
        out_valid <= 1'b1;
        out_data  <= beat;
        dcnt      <= dcnt + 1'b1;
        if (beat_last) begin
          st[dp] <= S_EMPTY;
          dp     <= ~dp;
          dcnt   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spmm_out_collector.sv
// Self-checking bench for spmm_out_collector. Reference model: a FIFO of completed
// N x N tiles; an os=1 tile adds onto the newest undrained tile, else it is appended.
module tb_spmm_out_collector;

  localparam int N   = 16;
  localparam int W   = 8;
  localparam int LGN = $clog2(N);
  localparam int NB  = N / 4;

  logic               clock = 1'b0;
  logic               reset;
  logic               res_ready;
  logic               res_valid;
  logic               res_os;
  logic [LGN-1:0]     res_row;
  logic [N*W-1:0]     res_data;
  logic               out_ready;
  logic               out_start;
  logic               out_valid;
  logic [4*N*W-1:0]   out_data;

  spmm_out_collector #(.N(N), .W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_os    (res_os),
    .res_row   (res_row),
    .res_data  (res_data),
    .out_ready (out_ready),
    .out_start (out_start),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  // stimulus tile and row send order
  logic [W-1:0] stim [N][N];
  int           order [N];

  // model: FIFO of completed tiles
  logic [W-1:0] mt [4][N][N];
  int           mhead = 0;
  int           mcnt  = 0;

  // captured drain
  logic [4*N*W-1:0] got_data [NB];
  logic             got_valid [NB];
  logic             pre_valid;
  logic             after_valid;

  task automatic model_complete(input bit os);
    int slot;
    if (os && mcnt > 0) begin
      slot = (mhead + mcnt - 1) % 4;
      for (int r = 0; r < N; r++)
        for (int j = 0; j < N; j++)
          mt[slot][r][j] = mt[slot][r][j] + stim[r][j];
    end else begin
      slot = (mhead + mcnt) % 4;
      for (int r = 0; r < N; r++)
        for (int j = 0; j < N; j++)
          mt[slot][r][j] = stim[r][j];
      mcnt++;
    end
  endtask

  task automatic model_pop();
    mhead = (mhead + 1) % 4;
    mcnt--;
  endtask

  function automatic logic [4*N*W-1:0] exp_beat(input int k);
    logic [4*N*W-1:0] v;
    v = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < N; j++)
        v[(i*N + j)*W +: W] = mt[mhead][4*k + i][j];
    return v;
  endfunction

  task automatic fill_const(input int val);
    for (int r = 0; r < N; r++) begin
      order[r] = r;
      for (int j = 0; j < N; j++) stim[r][j] = W'(val);
    end
  endtask

  task automatic fill_random();
    int a, t;
    for (int r = 0; r < N; r++) begin
      order[r] = r;
      for (int j = 0; j < N; j++) stim[r][j] = W'($urandom);
    end
    for (int r = N - 1; r > 0; r--) begin
      a = $urandom_range(0, r);
      t = order[r]; order[r] = order[a]; order[a] = t;
    end
  endtask

  // Send rows order[from..N-1]; waits on res_ready with a cycle bound.
  task automatic send_rows(input bit os, input int from, input bit gaps);
    int r, cnt;
    for (int idx = from; idx < N; idx++) begin
      r = order[idx];
      if (gaps && $urandom_range(0, 3) == 0) begin
        res_valid = 1'b0;
        @(posedge clock); #1;
      end
      res_valid = 1'b1;
      res_os    = os;
      res_row   = LGN'(r);
      for (int j = 0; j < N; j++) res_data[j*W +: W] = stim[r][j];
      cnt = 0;
      while (res_ready !== 1'b1 && cnt < 300) begin
        @(posedge clock); #1;
        cnt++;
      end
      if (cnt >= 300) begin
        nvec++; nerr++;
        $display("FAIL send_timeout row=%0d res_ready=%b required=1", r, res_ready);
      end
      @(posedge clock); #1;
    end
    res_valid = 1'b0;
    res_os    = 1'b0;
  endtask

  task automatic do_drain();
    int cnt;
    cnt = 0;
    while (out_ready !== 1'b1 && cnt < 300) begin
      @(posedge clock); #1;
      cnt++;
    end
    if (cnt >= 300) begin
      nvec++; nerr++;
      $display("FAIL drain_timeout out_ready=%b required=1", out_ready);
    end
    out_start = 1'b1;
    @(posedge clock); #1;
    out_start = 1'b0;
    pre_valid = out_valid;
    for (int k = 0; k < NB; k++) begin
      @(posedge clock); #1;
      got_valid[k] = out_valid;
      got_data[k]  = out_data;
    end
    @(posedge clock); #1;
    after_valid = out_valid;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    mhead = 0;
    mcnt  = 0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if (res_ready !== 1'b1) begin nerr++; $display("FAIL reset_res_ready got=%b exp=1", res_ready); end
    nvec++; if (out_ready !== 1'b0) begin nerr++; $display("FAIL reset_out_ready got=%b exp=0", out_ready); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    nvec++; if (out_data !== '0) begin nerr++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
  endtask

  task automatic test_basic();
    for (int r = 0; r < N; r++) begin
      order[r] = r;
      for (int j = 0; j < N; j++) stim[r][j] = W'(r + 1);
    end
    send_rows(1'b0, 0, 1'b0);
    model_complete(1'b0);
    nvec++; if (out_ready !== 1'b1) begin nerr++; $display("FAIL basic_out_ready_latency got=%b exp=1", out_ready); end
    do_drain();
    nvec++; if (pre_valid !== 1'b0) begin nerr++; $display("FAIL basic_pre_valid got=%b exp=0", pre_valid); end
    for (int k = 0; k < NB; k++) begin
      nvec++;
      if (got_valid[k] !== 1'b1 || got_data[k] !== exp_beat(k)) begin
        nerr++;
        $display("FAIL basic_beat%0d valid=%b got=%h exp=%h", k, got_valid[k], got_data[k], exp_beat(k));
      end
    end
    nvec++; if (after_valid !== 1'b0) begin nerr++; $display("FAIL basic_after_valid got=%b exp=0", after_valid); end
    model_pop();
  endtask

  task automatic test_reverse();
    for (int r = 0; r < N; r++) begin
      order[r] = N - 1 - r;
      for (int j = 0; j < N; j++) stim[r][j] = W'(2 * r);
    end
    send_rows(1'b0, 0, 1'b0);
    model_complete(1'b0);
    do_drain();
    for (int k = 0; k < NB; k++) begin
      nvec++;
      if (got_valid[k] !== 1'b1 || got_data[k] !== exp_beat(k)) begin
        nerr++;
        $display("FAIL reverse_beat%0d valid=%b got=%h exp=%h", k, got_valid[k], got_data[k], exp_beat(k));
      end
    end
    model_pop();
  endtask

  task automatic test_random();
    bit os_first, do_acc;
    for (int it = 0; it < 4; it++) begin
      os_first = 1'($urandom_range(0, 1));
      do_acc   = 1'($urandom_range(0, 1));
      fill_random();
      send_rows(os_first, 0, 1'b1);
      model_complete(os_first);
      if (do_acc) begin
        fill_random();
        send_rows(1'b1, 0, 1'b1);
        model_complete(1'b1);
      end
      do_drain();
      for (int k = 0; k < NB; k++) begin
        nvec++;
        if (got_valid[k] !== 1'b1 || got_data[k] !== exp_beat(k)) begin
          nerr++;
          $display("FAIL random%0d_beat%0d valid=%b got=%h exp=%h", it, k, got_valid[k], got_data[k], exp_beat(k));
        end
      end
      model_pop();
    end
  endtask

  task automatic test_os_wrap();
    fill_const(200);
    send_rows(1'b0, 0, 1'b0);
    model_complete(1'b0);
    fill_const(100);
    send_rows(1'b1, 0, 1'b0);
    model_complete(1'b1);
    nvec++; if (mt[mhead][0][0] !== 8'd44) begin nerr++; $display("FAIL os_model_value got=%0d exp=44", mt[mhead][0][0]); end
    nvec++; if (out_ready !== 1'b1) begin nerr++; $display("FAIL os_out_ready got=%b exp=1", out_ready); end
    nvec++; if (res_ready !== 1'b1) begin nerr++; $display("FAIL os_other_bank_empty res_ready=%b exp=1", res_ready); end
    do_drain();
    for (int k = 0; k < NB; k++) begin
      nvec++;
      if (got_valid[k] !== 1'b1 || got_data[k] !== exp_beat(k)) begin
        nerr++;
        $display("FAIL os_beat%0d valid=%b got=%h exp=%h", k, got_valid[k], got_data[k], exp_beat(k));
      end
    end
    model_pop();
    nvec++; if (out_ready !== 1'b0) begin nerr++; $display("FAIL os_single_full out_ready=%b exp=0", out_ready); end
  endtask

  task automatic test_back_to_back();
    fill_const(1);
    send_rows(1'b0, 0, 1'b0);
    model_complete(1'b0);
    fill_const(2);
    send_rows(1'b0, 0, 1'b0);
    model_complete(1'b0);
    fill_const(3);
    res_valid = 1'b1;
    res_os    = 1'b0;
    res_row   = '0;
    for (int j = 0; j < N; j++) res_data[j*W +: W] = stim[0][j];
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      nvec++; if (res_ready !== 1'b0) begin nerr++; $display("FAIL b2b_stall%0d res_ready=%b exp=0", c, res_ready); end
    end
    nvec++; if (out_ready !== 1'b1) begin nerr++; $display("FAIL b2b_out_ready got=%b exp=1", out_ready); end
    out_start = 1'b1;
    @(posedge clock); #1;
    out_start = 1'b0;
    nvec++; if (res_ready !== 1'b0) begin nerr++; $display("FAIL b2b_start_ready got=%b exp=0", res_ready); end
    for (int k = 0; k < NB; k++) begin
      @(posedge clock); #1;
      got_valid[k] = out_valid;
      got_data[k]  = out_data;
      nvec++;
      if (res_ready !== (k == NB - 1)) begin
        nerr++;
        $display("FAIL b2b_ready_beat%0d got=%b exp=%b", k, res_ready, (k == NB - 1));
      end
    end
    @(posedge clock); #1;
    res_valid = 1'b0;
    for (int k = 0; k < NB; k++) begin
      nvec++;
      if (got_valid[k] !== 1'b1 || got_data[k] !== exp_beat(k)) begin
        nerr++;
        $display("FAIL b2b_first_beat%0d valid=%b got=%h exp=%h", k, got_valid[k], got_data[k], exp_beat(k));
      end
    end
    model_pop();
    send_rows(1'b0, 1, 1'b0);
    model_complete(1'b0);
    for (int d = 0; d < 2; d++) begin
      do_drain();
      for (int k = 0; k < NB; k++) begin
        nvec++;
        if (got_valid[k] !== 1'b1 || got_data[k] !== exp_beat(k)) begin
          nerr++;
          $display("FAIL b2b_drain%0d_beat%0d valid=%b got=%h exp=%h", d + 2, k, got_valid[k], got_data[k], exp_beat(k));
        end
      end
      model_pop();
    end
  endtask

  task automatic test_ignored_start();
    logic [4*N*W-1:0] held;
    held = out_data;
    out_start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      nvec++;
      if (out_valid !== 1'b0 || out_ready !== 1'b0 || out_data !== held) begin
        nerr++;
        $display("FAIL ignored_start%0d valid=%b ready=%b data=%h exp_data=%h", c, out_valid, out_ready, out_data, held);
      end
    end
    out_start = 1'b0;
    nvec++; if (res_ready !== 1'b1) begin nerr++; $display("FAIL ignored_res_ready got=%b exp=1", res_ready); end
  endtask

  task automatic test_reset_mid_drain();
    fill_random();
    send_rows(1'b0, 0, 1'b0);
    model_complete(1'b0);
    out_start = 1'b1;
    @(posedge clock); #1;
    out_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      nvec++;
      if (out_valid !== 1'b1 || out_data !== exp_beat(k)) begin
        nerr++;
        $display("FAIL middrain_beat%0d valid=%b got=%h exp=%h", k, out_valid, out_data, exp_beat(k));
      end
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    mhead = 0;
    mcnt  = 0;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
    nvec++; if (out_data !== '0) begin nerr++; $display("FAIL rst_mid_data got=%h exp=0", out_data); end
    nvec++; if (out_ready !== 1'b0) begin nerr++; $display("FAIL rst_mid_out_ready got=%b exp=0", out_ready); end
    nvec++; if (res_ready !== 1'b1) begin nerr++; $display("FAIL rst_mid_res_ready got=%b exp=1", res_ready); end
    fill_random();
    send_rows(1'b0, 0, 1'b1);
    model_complete(1'b0);
    do_drain();
    for (int k = 0; k < NB; k++) begin
      nvec++;
      if (got_valid[k] !== 1'b1 || got_data[k] !== exp_beat(k)) begin
        nerr++;
        $display("FAIL post_reset_beat%0d valid=%b got=%h exp=%h", k, got_valid[k], got_data[k], exp_beat(k));
      end
    end
    model_pop();
  endtask

  initial begin
    reset     = 1'b1;
    res_valid = 1'b0;
    res_os    = 1'b0;
    res_row   = '0;
    res_data  = '0;
    out_start = 1'b0;
    @(posedge clock); #1;
    test_reset();
    test_basic();
    test_reverse();
    test_random();
    test_os_wrap();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/spmm_out_collector.md
Name: spmm_out_collector

Overview:
- Downstream stage of the PE array in the SpMM datapath.
- Collects completed result rows (one N-wide row per accepted cycle) into two N×N banks (double buffered).
- Supports output-stationary accumulation of a new tile onto the previous, not-yet-drained tile.
- Drains a full bank to the external port as 4 rows per cycle over N/4 cycles.

Parameters:
- N, 16, matrix dimension; multiple of 4, power of 2.
- W, 8, element width in bits.
- LGN, $clog2(N), row-index width (derived, not overridden).

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- res_ready  out  1  collector can accept a result row this cycle.
- res_valid  in  1  result row present.
- res_os  in  1  tile mode, sampled on first row of a tile; 1 = accumulate onto the last completed tile.
- res_row  in  LGN  destination row index.
- res_data  in  N×W  result row, element j = column j.
- out_ready  out  1  a full bank is available to drain.
- out_start  in  1  drain request.
- out_valid  out  1  out_data carries a valid beat.
- out_data  out  4×N×W  beat k: out_data[i] = row 4k+i.

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clock.
- Bank states: each bank B0/B1 is EMPTY, FILLING, FULL or DRAINING.
- Pointers and counters:
  - fp: fill bank.
  - dp: drain bank (oldest FULL).
  - lp: last completed bank.
  - rcnt: 0..N-1 rows accepted in the current tile.
  - dcnt: 0..N/4-1 drain beat.
- Reset values:
  - Both banks EMPTY; fp=dp=lp=0; rcnt=dcnt=0.
  - out_valid=0, out_data=0, out_ready=0, res_ready=1.
  - Bank contents are not cleared; WRITE mode overwrites them.
- Transfer: occurs when res_valid & res_ready.
- Tile start (rcnt==0), target selection:
  - If res_os=1 and state[lp]==FULL: target=lp, mode ACC.
  - Otherwise: target=fp, mode WRITE.
  - Target goes to FILLING.
- res_ready:
  - rcnt!=0: 1.
  - rcnt==0: (state[fp]==EMPTY) | (res_os & state[lp]==FULL). Combinational in res_os; all other terms registered.
- Row update:
  - WRITE: bank[res_row] = res_data.
  - ACC: bank[res_row][j] += res_data[j], truncated mod 2^W, no saturation.
  - Accepted cycle t, visible in the bank at t+1.
- Tile completion: on the N-th transfer (rcnt==N-1), in the same edge:
  - target → FULL, lp=target, fp=target^1, rcnt=0.
- Row coverage:
  - Each row index appears exactly once per tile.
  - Duplicate or missing rows are a caller error: WRITE last-wins, ACC double-adds, missing rows keep stale data.
- out_ready = (state[dp]==FULL) & no drain in progress.
- Drain:
  - out_start & out_ready at edge t → bank dp DRAINING.
  - Beats k=0..N/4-1 registered on edges t+1..t+N/4: out_valid=1, out_data[i]=bank[dp][4k+i].
  - On the last beat the bank → EMPTY and dp toggles. Next edge: out_valid=0.
  - out_data holds the last beat value while out_valid=0.
  - out_start while out_ready=0 is ignored.
- OS restriction: ACC never targets a DRAINING or EMPTY bank; such a tile falls back to WRITE into fp.
- Simultaneous events:
  - A bank reaching FULL is drainable next cycle; out_ready rises one cycle after the last accepted row.
  - A bank leaving DRAINING is fillable next cycle.
  - Fill and drain of different banks proceed concurrently.
  - Caller must not out_start between a tile's completion and an os=1 follow-up tile.
- Reset mid-operation: partial tile discarded, drain aborted; all outputs at reset values the cycle after reset.
- Total latency: last row accepted at t → out_ready at t+1 → out_start at t+1 → beats at t+2..t+1+N/4.

Test Plan:
- Basic (N=16, W=8):
  - Stimulus: one WRITE tile, rows in order, row r all elements = r+1; out_start when out_ready.
  - Required: 4 beats, beat k out_data[i] all = 4k+i+1; out_valid exactly 4 cycles.
- Reverse order:
  - Stimulus: rows sent 15..0 with value 2r.
  - Required: drain beat 0 rows = 0,2,4,6.
- OS accumulate and wrap:
  - Stimulus: tile A all 200 (os=0), then tile B all 100 (os=1), no drain between.
  - Required: single FULL bank, all elements = 44; second bank stays EMPTY.
- Backpressure and ordering:
  - Stimulus: two WRITE tiles (all 1, all 2), then third tile's first row with os=0.
  - Required:
    - res_ready=0 until the first drain's last beat, then 1.
    - Drains return the all-1 tile before the all-2 tile.
- Ignored start:
  - Stimulus: out_start with both banks EMPTY.
  - Required: out_valid stays 0, state unchanged.
- Reset mid-drain:
  - Stimulus: assert reset after 2 beats.
  - Required: next cycle out_valid=0, out_data=0, out_ready=0, res_ready=1; a fresh tile fills B0 correctly.
